// File: rtl/maze_mem_arbiter.sv
// Arbiter sharing the single-port maze tile RAM between the video renderer
// (strict priority, fixed 3-cycle read latency) and the game logic (req/ack).
module maze_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_data_o,
  input  logic              gm_req_i,
  input  logic              gm_we_i,
  input  logic [ADDR_W-1:0] gm_addr_i,
  input  logic [DATA_W-1:0] gm_wdata_i,
  output logic              gm_ack_o,
  output logic [DATA_W-1:0] gm_rdata_o,
  output logic              gm_starve_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {G_IDLE, G_CMD, G_DATA, G_ACK} gstate_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_GAME} owner_e;

  localparam logic [7:0] STARVE_CNT = 8'(STARVE_MAX);

  gstate_e           state_q, state_d;
  owner_e            tag1_q, tag1_d, tag2_q, tag2_d;
  logic              gm_we_q, gm_we_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              gm_ack_q, gm_ack_d;
  logic [DATA_W-1:0] gm_rdata_q, gm_rdata_d;

  // Next-state: command slot selection, game FSM, starvation counter, capture.
  always_comb begin
    state_d     = state_q;
    gm_we_d     = gm_we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    tag1_d      = OWN_NONE;
    gm_ack_d    = 1'b0;

    // Video always owns the next slot; the game only gets a slot video leaves idle.
    if (vid_req_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = vid_addr_i;
      tag1_d     = OWN_VID;
    end else if (state_q == G_IDLE && gm_req_i) begin
      mem_en_d    = 1'b1;
      mem_we_d    = gm_we_i;
      mem_addr_d  = gm_addr_i;
      mem_wdata_d = gm_wdata_i;
      tag1_d      = OWN_GAME;
    end else begin
      mem_en_d = 1'b0;
    end

    case (state_q)
      G_IDLE: begin
        if (gm_req_i && !vid_req_i) begin
          state_d = G_CMD;
          gm_we_d = gm_we_i;
          cnt_d   = 8'd0;
        end else if (gm_req_i) begin
          if (cnt_q != STARVE_CNT) cnt_d = cnt_q + 8'd1;
          else                     cnt_d = cnt_q;
        end else begin
          cnt_d = 8'd0;
        end
      end
      G_CMD:   state_d = G_DATA;
      G_DATA: begin
        state_d  = G_ACK;
        gm_ack_d = 1'b1;
      end
      G_ACK:   state_d = G_IDLE;
      default: state_d = G_IDLE;
    endcase

    starve_d = (cnt_d == STARVE_CNT);
    tag2_d   = tag1_q;

    if (tag2_q == OWN_VID) begin
      vid_valid_d = 1'b1;
      vid_data_d  = mem_rdata_i;
    end else begin
      vid_valid_d = 1'b0;
      vid_data_d  = vid_data_q;
    end

    if (tag2_q == OWN_GAME && !gm_we_q) gm_rdata_d = mem_rdata_i;
    else                                gm_rdata_d = gm_rdata_q;
  end

  // State and registered outputs, all cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= G_IDLE;
      tag1_q      <= OWN_NONE;
      tag2_q      <= OWN_NONE;
      gm_we_q     <= 1'b0;
      cnt_q       <= 8'd0;
      starve_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      gm_ack_q    <= 1'b0;
      gm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      gm_we_q     <= gm_we_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      gm_ack_q    <= gm_ack_d;
      gm_rdata_q  <= gm_rdata_d;
    end
  end

  assign vid_valid_o = vid_valid_q;
  assign vid_data_o  = vid_data_q;
  assign gm_ack_o    = gm_ack_q;
  assign gm_rdata_o  = gm_rdata_q;
  assign gm_starve_o = starve_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
